// File: rtl/sipo_deserializer_rx_pkg.sv
// rtl/sipo_deserializer_rx_pkg.sv - shared FSM and bit-order encodings for the serial datapath
package sipo_deserializer_rx_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   // Bit-order encodings are common with the transmit shifters.
   localparam logic [0:0] ORDER_LSB = 1'b0;
   localparam logic [0:0] ORDER_MSB = 1'b1;

endpackage

// File: rtl/sipo_out_buffer.sv
// rtl/sipo_out_buffer.sv - single-entry valid/ready output register with drop and sticky overrun
module sipo_out_buffer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             dout_ready,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             overrun
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             pop;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      pop     = valid_q & dout_ready;
      if (clear) begin
         data_d  = '0;
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end else if (load) begin
         // A pop in the same cycle frees the slot, so the new word is not dropped.
         if (!valid_q || pop) begin
            data_d  = load_data;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign dout       = data_q;
   assign dout_valid = valid_q;
   assign overrun    = ovr_q;

endmodule

// File: rtl/sipo_deserializer_rx.sv
// rtl/sipo_deserializer_rx.sv - serial-to-parallel receiver with per-word bit order and output buffer
module sipo_deserializer_rx
   import sipo_deserializer_rx_pkg::*;
#(
   parameter int WIDTH = 16,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             msb_first,
   input  logic             ser_valid,
   input  logic             ser_data,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [0:0]       order_q, order_d;
   logic [0:0]       order_cur;
   logic [WIDTH-1:0] sh_shifted;
   logic             accept;
   logic             complete;

   always_comb begin
      accept     = ser_valid & ~clear;
      // Bit order is sampled only on the first bit of a word.
      order_cur  = (state_q == ST_IDLE) ? msb_first : order_q;
      sh_shifted = (order_cur == ORDER_MSB) ? {sh_q[WIDTH-2:0], ser_data}
                                            : {ser_data, sh_q[WIDTH-1:1]};
      complete   = accept && (cnt_q == CNT_LAST);

      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      order_d = order_q;
      if (clear) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         sh_d    = '0;
      end else if (accept) begin
         order_d = order_cur;
         if (complete) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sh_d    = '0;
         end else begin
            state_d = ST_SHIFT;
            cnt_d   = cnt_q + CNT_W'(1);
            sh_d    = sh_shifted;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         order_q <= ORDER_LSB;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         order_q <= order_d;
      end
   end

   sipo_out_buffer #(.WIDTH(WIDTH)) u_out_buffer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .load       (complete),
      .load_data  (sh_shifted),
      .dout_ready (dout_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .overrun    (overrun)
   );

   assign busy    = (state_q == ST_SHIFT);
   assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_sipo_deserializer_rx.sv
// tb/tb_sipo_deserializer_rx.sv - directed self-checking bench for sipo_deserializer_rx
module tb_sipo_deserializer_rx;

   logic        clk = 1'b0;
   logic        rst_n, clear, msb_first, ser_valid, ser_data, dout_ready;
   logic [15:0] dout;
   logic        dout_valid, busy, overrun;
   logic [3:0]  bit_cnt;
   int          n_checks = 0;
   int          n_pass   = 0;

   sipo_deserializer_rx #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .msb_first  (msb_first),
      .ser_valid  (ser_valid),
      .ser_data   (ser_data),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .bit_cnt    (bit_cnt),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Drives nbits bits of w at successive negedges; returns at the negedge after the last bit.
   task automatic send_bits(input logic [15:0] w, input bit msb, input bit tog,
                            input bit rdy_last, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ser_valid = 1'b1;
         ser_data  = msb ? w[15-i] : w[i];
         msb_first = (tog && i > 0) ? ~msb : msb;
         if (rdy_last && i == 15) dout_ready = 1'b1;
      end
      @(negedge clk);
      ser_valid = 1'b0;
      msb_first = msb;
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; msb_first = 1'b1; ser_valid = 1'b0;
      ser_data = 1'b0; dout_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_dout", dout, 0);
      check("rst_valid", dout_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_cnt", bit_cnt, 0);
      check("rst_ovr", overrun, 0);
      rst_n = 1'b1;

      // MSB-first 0xA5C3, single-cycle valid pulse
      dout_ready = 1'b1;
      send_bits(16'hA5C3, 1'b1, 1'b0, 1'b0, 15);
      check("msb_pre_valid", dout_valid, 0);
      check("msb_pre_cnt", bit_cnt, 15);
      send_bits(16'hA5C3 << 15, 1'b1, 1'b0, 1'b0, 1);
      check("msb_valid", dout_valid, 1);
      check("msb_dout", dout, 16'hA5C3);
      check("msb_cnt_wrap", bit_cnt, 0);
      @(negedge clk);
      check("msb_pulse", dout_valid, 0);

      // LSB-first with msb_first toggled mid-word
      send_bits(16'hA5C3, 1'b0, 1'b1, 1'b0, 16);
      check("lsb_valid", dout_valid, 1);
      check("lsb_dout", dout, 16'hA5C3);

      // Two words with consumer stalled -> overrun
      @(negedge clk);
      dout_ready = 1'b0;
      send_bits(16'h1234, 1'b1, 1'b0, 1'b0, 16);
      check("w1_dout", dout, 16'h1234);
      check("w1_ovr", overrun, 0);
      send_bits(16'hBEEF, 1'b1, 1'b0, 1'b0, 16);
      check("w2_dout_held", dout, 16'h1234);
      check("w2_valid", dout_valid, 1);
      check("w2_ovr", overrun, 1);
      dout_ready = 1'b1;
      @(negedge clk);
      check("pop_valid", dout_valid, 0);
      check("ovr_sticky", overrun, 1);
      repeat (3) @(negedge clk);
      check("ovr_sticky2", overrun, 1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_ovr", overrun, 0);

      // Completion coinciding with a pop
      dout_ready = 1'b0;
      send_bits(16'h1111, 1'b1, 1'b0, 1'b0, 16);
      send_bits(16'h2222, 1'b1, 1'b0, 1'b1, 16);
      check("swap_valid", dout_valid, 1);
      check("swap_dout", dout, 16'h2222);
      check("swap_ovr", overrun, 0);
      @(negedge clk);
      check("swap_drain", dout_valid, 0);

      // 7 bits, then clear with a bit present
      send_bits(16'hFFFF, 1'b1, 1'b0, 1'b0, 7);
      check("part_cnt", bit_cnt, 7);
      check("part_busy", busy, 1);
      clear = 1'b1; ser_valid = 1'b1; ser_data = 1'b1;
      @(negedge clk);
      clear = 1'b0; ser_valid = 1'b0;
      check("clr_cnt", bit_cnt, 0);
      check("clr_busy", busy, 0);
      send_bits(16'h00FF, 1'b1, 1'b0, 1'b0, 16);
      check("clr_next_dout", dout, 16'h00FF);
      check("clr_next_valid", dout_valid, 1);

      // Async reset mid-word with a word pending
      dout_ready = 1'b0;
      @(negedge clk);
      send_bits(16'h5A5A, 1'b1, 1'b0, 1'b0, 16);
      send_bits(16'hFFFF, 1'b1, 1'b0, 1'b0, 5);
      check("pre_rst_valid", dout_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", dout_valid, 0);
      check("arst_dout", dout, 0);
      check("arst_cnt", bit_cnt, 0);
      check("arst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 5-cycle gaps inside a word
      dout_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         ser_valid = 1'b1;
         ser_data  = logic'((16'hC0DE >> (15 - i)) & 1);
         if (i == 4 || i == 11) begin
            @(negedge clk);
            ser_valid = 1'b0;
            repeat (5) @(negedge clk);
            check("gap_no_valid", dout_valid, 0);
            check("gap_cnt", bit_cnt, i + 1);
            ser_valid = 1'b1;
            ser_data  = logic'((16'hC0DE >> (15 - i)) & 1);
            i++;
            ser_data  = logic'((16'hC0DE >> (15 - i)) & 1);
         end
      end
      @(negedge clk);
      ser_valid = 1'b0;
      check("gap_valid", dout_valid, 1);
      check("gap_dout", dout, 16'hC0DE);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
